mux_n_1_reg: RTL
================

Name: mux_n_1_reg

Overview:
- Parametrised, registered N:1 selector. Generalises the 1-bit 16:1 combinational mux to WIDTH-bit channels and CHANNELS inputs.
- Adds a valid/ready handshake, a one-cycle output register and an auto-scan mode that steps through channels on each accepted transfer.
- Used by the CPU datapath for register-file read ports and for debug/trace sweeps of register contents.

Parameters:
- WIDTH, 4, bits per channel.
- CHANNELS, 16, number of input channels; any value 2..2**SEL_W, not required to be a power of two.
- SEL_W, 4, select/pointer width; must satisfy 2**SEL_W >= CHANNELS.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  CHANNELS*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- sel  in  SEL_W  channel select, used when scan=0.
- scan  in  1  0 = direct select, 1 = auto-scan using internal pointer.
- in_valid  in  1  request to capture one channel.
- in_ready  out  1  block can accept this cycle.
- res  out  WIDTH  registered selected data.
- res_ch  out  SEL_W  channel index that produced res.
- res_valid  out  1  res/res_ch/sel_err hold an unconsumed result.
- out_ready  in  1  downstream consumes result this cycle.
- sel_err  out  1  captured channel index was >= CHANNELS.

Behaviour:
- Reset (rst=1 at a clock edge):
  - res=0, res_ch=0, res_valid=0, sel_err=0, scan_ptr=0.
  - Any pending result is discarded.
  - rst overrides all other inputs that cycle.
- in_ready = !res_valid || out_ready (combinational). A full register with out_ready=1 accepts in the same cycle (no bubble).
- accept = in_valid && in_ready.
- Effective channel: ch = scan ? scan_ptr : sel.
- On accept:
  - res <= din slice ch, or 0 if ch >= CHANNELS.
  - res_ch <= ch.
  - sel_err <= (ch >= CHANNELS).
  - res_valid <= 1.
- Latency: data sampled in the accept cycle and visible the next cycle. Later changes to din do not alter a held result.
- No accept and out_ready=1 while res_valid=1: res_valid <= 0. res, res_ch and sel_err hold their last values.
- No accept and out_ready=0: all outputs hold.
- scan_ptr update on accept only:
  - Both modes: next value is ch+1, wrapping to 0 when ch >= CHANNELS-1.
  - So a scan after a direct read continues from the channel after the direct read.
  - An out-of-range direct sel wraps the pointer to 0.
- scan_ptr never holds a value >= CHANNELS, so sel_err is only reachable in direct mode.
- Toggling scan with no accept has no effect on state.
- Simultaneous consume and accept in one cycle: the new result replaces the old, res_valid stays 1, no cycle lost.
- in_valid deasserted: no state change apart from consumption.

Test Plan:
- Reset/idle: assert rst 2 cycles with in_valid=1 → res=0, res_ch=0, res_valid=0, sel_err=0; in_ready=1 after reset.
- Direct select, defaults: din channel k = k mod 16; sel=9, in_valid=1 one cycle, out_ready=1 → next cycle res=9, res_ch=9, res_valid=1, sel_err=0; res_valid falls the following cycle.
- Backpressure: out_ready=0, accept sel=3 (res=3), then hold in_valid=1 with sel=5 → in_ready=0, res stays 3 for 4 cycles. Raise out_ready → that cycle accepts sel=5, res=5 next cycle with no bubble.
- Scan wrap: direct read sel=14, then scan=1 with in_valid=1 and out_ready=1 for 4 cycles → res_ch sequence 14,15,0,1,2.
- Out-of-range: CHANNELS=10, SEL_W=4, sel=12 → res=0, res_ch=12, sel_err=1. A following scan accept gives res_ch=0, sel_err=0.
- Mid-operation reset: res_valid=1 with out_ready=0, assert rst one cycle → res_valid=0, scan_ptr=0. The next scan accept yields res_ch=0.

Source files
------------

// File: rtl/mux_n_1_reg.sv
// rtl/mux_n_1_reg.sv - registered N:1 channel selector with valid/ready handshake and auto-scan
module mux_n_1_reg #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 16,
    parameter int SEL_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      scan,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [WIDTH-1:0]          res,
    output logic [SEL_W-1:0]          res_ch,
    output logic                      res_valid,
    input  logic                      out_ready,
    output logic                      sel_err
);

    // One extra bit so CHANNELS == 2**SEL_W is representable.
    localparam logic [SEL_W:0] CH_LIMIT = (SEL_W + 1)'(CHANNELS);

    logic [WIDTH-1:0] res_q, res_d;
    logic [SEL_W-1:0] res_ch_q, res_ch_d;
    logic             res_valid_q, res_valid_d;
    logic             sel_err_q, sel_err_d;
    logic [SEL_W-1:0] scan_ptr_q, scan_ptr_d;

    logic             accept;
    logic [SEL_W-1:0] ch;
    logic             ch_oor;
    logic             ch_wrap;
    logic [WIDTH-1:0] ch_data;

    assign in_ready = !res_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign ch       = scan ? scan_ptr_q : sel;
    assign ch_oor   = ({1'b0, ch} >= CH_LIMIT);
    assign ch_wrap  = ({1'b0, ch} >= (CH_LIMIT - 1'b1));

    always_comb begin
        ch_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch == SEL_W'(k)) begin
                ch_data = din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        res_d       = res_q;
        res_ch_d    = res_ch_q;
        res_valid_d = res_valid_q;
        sel_err_d   = sel_err_q;
        scan_ptr_d  = scan_ptr_q;
        if (accept) begin
            res_d       = ch_oor ? '0 : ch_data;
            res_ch_d    = ch;
            sel_err_d   = ch_oor;
            res_valid_d = 1'b1;
            // Pointer follows the last captured channel in either mode.
            scan_ptr_d  = ch_wrap ? '0 : ch + SEL_W'(1);
        end else if (out_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q       <= '0;
            res_ch_q    <= '0;
            res_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            scan_ptr_q  <= '0;
        end else begin
            res_q       <= res_d;
            res_ch_q    <= res_ch_d;
            res_valid_q <= res_valid_d;
            sel_err_q   <= sel_err_d;
            scan_ptr_q  <= scan_ptr_d;
        end
    end

    assign res       = res_q;
    assign res_ch    = res_ch_q;
    assign res_valid = res_valid_q;
    assign sel_err   = sel_err_q;

endmodule
